// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Holds the fetch PC, issues in-order
//               req/gnt requests to instruction memory, collects rvalid
//               responses in a small queue whose head feeds the IF/ID
//               register. A redirect squashes queued and in-flight fetches.
//               Optional macro FETCH_BYPASS_EN: a response arriving while the
//               queue is empty drives the head combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instrF,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic                  validF
);

    localparam int                    c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                    c_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CNT_W:0]      c_DEPTH   = (c_CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] c_PC_STEP = DATA_WIDTH'(4);

    logic [DATA_WIDTH-1:0] r_req_pc;
    logic [DATA_WIDTH-1:0] r_rsp_pc;
    logic [c_CNT_W-1:0]    r_inflight;
    logic [c_CNT_W-1:0]    r_drop;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_instr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_pc_q    [FIFO_DEPTH];

    logic                  w_rsp;
    logic                  w_drop_rsp;
    logic                  w_keep;
    logic                  w_q_empty;
    logic                  w_q_pop;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_grant;
    logic [c_CNT_W:0]      w_used;
    logic [DATA_WIDTH-1:0] w_target;
    logic                  w_head_valid;
    logic [DATA_WIDTH-1:0] w_head_instr;
    logic [DATA_WIDTH-1:0] w_head_pc;
    logic                  w_unused;

    // Low address bits of the redirect target are architecturally ignored.
    assign w_unused   = ^redirect_pc[1:0];
    assign w_target   = {redirect_pc[DATA_WIDTH-1:2], 2'b00};

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp      = imem_rvalid && (r_inflight != '0);
    assign w_drop_rsp = w_rsp && (r_drop != '0);
    assign w_keep     = w_rsp && (r_drop == '0) && !redirect;
    assign w_q_empty  = (r_count == '0);
    assign w_q_pop    = enable && !w_q_empty && !redirect;

`ifdef FETCH_BYPASS_EN
    assign w_bypass   = w_q_empty && w_rsp && (r_drop == '0);
`else
    assign w_bypass   = 1'b0;
`endif

    // A bypassed response consumed in the same cycle never occupies a slot.
    assign w_push     = w_keep && !(w_bypass && enable);

    // Slots already claimed; the head leaving this cycle frees its slot so
    // streaming with a single-cycle memory sustains one fetch per cycle.
    assign w_used     = {1'b0, r_inflight} + {1'b0, r_count} - (c_CNT_W + 1)'(w_q_pop);
    assign imem_req   = rst_n && !redirect && (w_used < c_DEPTH);
    assign imem_addr  = r_req_pc;
    assign w_grant    = imem_req && imem_gnt;

    // Head selection: queued entry first, otherwise the bypassed response.
    always_comb begin
        w_head_valid = 1'b0;
        w_head_instr = '0;
        w_head_pc    = '0;
        if (!w_q_empty) begin
            w_head_valid = 1'b1;
            w_head_instr = r_instr_q[r_rd_ptr];
            w_head_pc    = r_pc_q[r_rd_ptr];
        end else if (w_bypass) begin
            w_head_valid = 1'b1;
            w_head_instr = imem_rdata;
            w_head_pc    = r_rsp_pc;
        end
    end

    assign validF   = w_head_valid;
    assign instrF   = w_head_instr;
    assign PCF      = w_head_pc;
    assign PCPlus4F = w_head_valid ? (w_head_pc + c_PC_STEP) : '0;

    // Queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_q_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_q_pop);
        end
    end

    // Queue storage needs no reset; occupancy qualifies every entry.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_q[r_wr_ptr] <= imem_rdata;
            r_pc_q[r_wr_ptr]    <= r_rsp_pc;
        end
    end

    // Outstanding-request and discard counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            r_inflight <= r_inflight + c_CNT_W'(w_grant) - c_CNT_W'(w_rsp);
            if (redirect) begin
                r_drop <= r_inflight - c_CNT_W'(w_rsp);
            end else if (w_drop_rsp) begin
                r_drop <= r_drop - c_CNT_W'(1);
            end
        end
    end

    // Request and response program counters; wrap-around is silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_pc <= RESET_PC;
            r_rsp_pc <= RESET_PC;
        end else if (redirect) begin
            r_req_pc <= w_target;
            r_rsp_pc <= w_target;
        end else begin
            if (w_grant) begin
                r_req_pc <= r_req_pc + c_PC_STEP;
            end
            if (w_keep) begin
                r_rsp_pc <= r_rsp_pc + c_PC_STEP;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the pipelined core. Holds the fetch PC, issues in-order requests to instruction memory over a req/gnt + rvalid interface, and buffers returned instructions in a small queue. The queue head drives the IF/ID pipeline register (`instrF`/`PCF`/`PCPlus4F`), and a `redirect` from execute squashes all in-flight and queued fetches.

## Interface
- `DATA_WIDTH`, 32: instruction and address width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `FIFO_DEPTH`, 2: instruction queue entries; power of two, ≥2. Also caps in-flight plus queued fetches.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  consumer (IF/ID register) accepts the head this cycle; low means stall.
- `redirect`  in  1  taken branch/jump from execute.
- `redirect_pc`  in  DATA_WIDTH  new fetch target; bits [1:0] ignored (forced 00).
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  DATA_WIDTH  fetch address, word aligned.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid; in order; ≥1 cycle after its grant.
- `imem_rdata`  in  DATA_WIDTH  response instruction.
- `instrF`  out  DATA_WIDTH  head instruction; 0 when `validF`=0.
- `PCF`  out  DATA_WIDTH  PC of the head; 0 when `validF`=0.
- `PCPlus4F`  out  DATA_WIDTH  `PCF`+4; 0 when `validF`=0.
- `validF`  out  1  head valid. The consumer inserts a bubble (flush) when low.

## Operation
- State:
  - `req_pc`: next address to request.
  - `rsp_pc`: PC of the next kept response.
  - `inflight`: granted, not yet returned.
  - `drop`: in-flight responses to discard, subset of `inflight`.
  - Queue of {instr, pc}.
- Credit: `imem_req` = (`inflight` + queue count < FIFO_DEPTH) && !`redirect`.
- `imem_addr` = `req_pc`. While `imem_req`=1 and `imem_gnt`=0, `imem_addr` holds stable.
- Grant (`imem_req` && `imem_gnt`): `req_pc` += 4, `inflight` += 1.
- Response (`imem_rvalid`): `inflight` -= 1.
  - If `drop`>0: `drop` -= 1, data discarded.
  - Otherwise: push {`imem_rdata`, `rsp_pc`} and `rsp_pc` += 4.
  - `imem_rvalid` with `inflight`=0 is a protocol error and is ignored.
- Pop: `enable` && `validF` removes the head.
- Redirect:
  - Queue cleared, pop ignored.
  - `drop` ← `inflight` − (`imem_rvalid` ? 1 : 0). A response arriving in the redirect cycle is discarded.
  - `req_pc` and `rsp_pc` ← {`redirect_pc`[31:2], 2'b00}.
  - The first request to the new target is issued the cycle after redirect.
- Address arithmetic is modulo 2^DATA_WIDTH; wrap from 0xFFFF_FFFC to 0 is silent.
- Simultaneous push and pop on a full queue cannot occur because credit bounds occupancy.

## Timing
- Reset (`rst_n` low, async):
  - `req_pc`=`rsp_pc`=RESET_PC; `inflight`=`drop`=0; queue empty.
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `validF`=0; `instrF`=`PCF`=`PCPlus4F`=0.
- First cycle after `rst_n` rises: `imem_req`=1, `imem_addr`=RESET_PC.
- Reset mid-operation discards all in-flight state; the memory is reset with the core.
- Latency, grant to `validF` (baseline): response returned in cycle N is visible at the head in cycle N+1.
- Throughput: one instruction per cycle with a 1-cycle memory when FIFO_DEPTH ≥ 2 and `enable`=1.
- Redirect penalty: redirect at cycle R, request at R+1, head valid no earlier than R+3 with a 1-cycle memory.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When the queue is empty, `imem_rvalid`=1 and `drop`=0, the response drives `instrF`/`PCF`/`PCPlus4F`/`validF`=1 combinationally in the same cycle.
  - If `enable`=1 that cycle, it is consumed without entering the queue; otherwise it is pushed.
  - Latency becomes response cycle N → head in cycle N.
- Undefined: all responses pass through the queue (latency N+1). Outputs are registered-path only.

## Test plan
- Reset: `rst_n`=0 mid-stream → immediately `imem_req`=0, `validF`=0, `instrF`=0. Release → next cycle `imem_req`=1, `imem_addr`=0x0.
- Streaming with a 1-cycle memory, `gnt`=1, `enable`=1 → `PCF` sequence 0x0, 0x4, 0x8… with `validF` continuous after the first. `instrF` matches memory at each PC. First valid is 2 cycles after the first grant, or 1 cycle with `FETCH_BYPASS_EN`.
- Stall: `enable`=0 for 5 cycles → queue reaches 2, `imem_req` drops to 0, `PCF` held. Release → no instruction lost or duplicated.
- Redirect with 2 fetches in flight, `redirect_pc`=0x100 → both responses discarded. Next `validF`=1 shows `PCF`=0x100, `PCPlus4F`=0x104.
- Back-pressure: `imem_gnt`=0 for 3 cycles → `imem_addr` constant and `req_pc` unchanged. Grant → advances by exactly 4.
- Misaligned target: `redirect_pc`=0x103 → `imem_addr`=0x100 and `PCF`=0x100.
